cineraria_core_gpio_edgecap: RTL and testbench
==============================================

Name: cineraria_core_gpio_edgecap

Overview:
Pin-side input conditioner and edge-capture interrupt unit for the cineraria_core GPIO ports. Takes the raw external pin levels that the GPIO port reads back, and does four things: synchronises them, optionally glitch-filters them, captures selected edges into sticky bits, and raises a maskable level interrupt to the Nios II. Exposed as a 4-word Avalon-MM slave with the same bus timing as the GPIO slave (registered readdata, zero write wait states).

Parameters:
WIDTH, 32, number of input bits (1..32); unused readdata bits read 0.
SYNC_STAGES, 2, synchroniser flops per bit (2..4).

Ports:
clk  in  1  system clock; one clock domain only.
reset_n  in  1  asynchronous, active-low reset.
address  in  2  word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  registered read data.
pin_in  in  WIDTH  raw asynchronous pin levels.
irq  out  1  registered level interrupt, active high.

Behaviour:
- Reset (asynchronous on reset_n low, also when asserted mid-operation) clears:
  - readdata=0, irq=0, mask=0, capture=0.
  - All synchroniser flops, filt and prev = 0.
  - ctrl = 0x00000001 (rising edge enabled, filter bypass).
  - prime counter = 0.
- Register map (32-bit words):
  - addr 0 DATA (RO): filt[WIDTH-1:0].
  - addr 1 MASK (RW): irq enable per bit.
  - addr 2 EDGE (R/W1C): capture bits; writing 1 clears, writing 0 has no effect.
  - addr 3 CTRL (RW): bit0 RISE_EN, bit1 FALL_EN, bits[23:8] DIV, all other bits read 0.
- Write: chipselect & ~write_n; takes effect at that clock edge. Writes to addr 0 are ignored.
- Read: readdata <= mux(address) every clock, independent of chipselect. Read latency is 1 cycle.
- Synchroniser: SYNC_STAGES flop chain per bit; sync_out is the last stage.
- Filter:
  - DIV==0: bypass; filt <= sync_out every cycle.
  - DIV>0: 16-bit prescaler counts down from DIV to 0. tick=1 when the count is 0, then it reloads DIV, giving a tick period of DIV+1 cycles.
  - On tick: samp <= sync_out, and per bit filt <= sync_out only where sync_out==samp. A bit must therefore be stable over two consecutive ticks to pass.
  - A write to CTRL reloads the prescaler with the new DIV at the same edge; no tick occurs in that cycle. filt and samp are kept.
- Edge detect: prev <= filt every cycle.
  - rise = filt & ~prev & {RISE_EN}; fall = ~filt & prev & {FALL_EN}.
- Priming: a 3-bit prime counter increments from reset until it reaches SYNC_STAGES+1 and then saturates. Edge detect is forced to 0 until it saturates. This suppresses the spurious rising edge seen when pins are high at reset release.
- Capture: capture <= (capture & ~clr) | rise | fall, where clr = writedata on an EDGE write. If set and clear hit the same bit in the same cycle, set wins; no edge is lost.
- irq <= |(capture & mask), registered. Writing MASK or clearing EDGE takes effect on irq one cycle after the write edge.
- Latency, bypass mode: a pin level sampled at edge N appears as:
  - filt/DATA at edge N+SYNC_STAGES.
  - capture bit at N+SYNC_STAGES+1.
  - irq at N+SYNC_STAGES+2.
- Pulses shorter than one clock may be missed; there is no requirement to catch them.
- Both RISE_EN and FALL_EN = 0: capture holds its value and only clears by W1C.

Test Plan:
1. Reset with pin_in=0xFFFFFFFF, release, wait 10 cycles -> EDGE reads 0, DATA reads 0xFFFFFFFF, irq=0 (priming suppresses the edge).
2. Bypass, MASK=0x1, pin_in[0] 0->1 sampled at edge N -> DATA bit0=1 at N+2, EDGE=0x1 at N+3, irq=1 at N+4. Write EDGE=0x1 -> irq=0 one cycle after the write edge.
3. CTRL=0x2 (falling only), pin_in[5] 1->0->1 -> EDGE=0x20 only. Write EDGE=0x0 -> EDGE still 0x20.
4. CTRL=0x00000401 (DIV=4), 3-cycle glitch on pin_in[3] -> DATA and EDGE unchanged. 20-cycle pulse -> DATA bit3 rises within 2 ticks (≤10 cycles after sync), EDGE=0x8.
5. Edge on bit2 arriving in the same cycle as a W1C write of 0x4 -> EDGE bit2 remains 1.
6. Assert reset_n mid-capture with MASK=0xF and EDGE=0x3 -> readdata, irq, EDGE and MASK go to 0 immediately (asynchronously); CTRL reads 0x1 after release.

Source files
------------

// File: rtl/cineraria_core_gpio_edgecap.sv
// Pin-side input conditioner and edge-capture interrupt unit for the GPIO ports.
// Synchronises raw pin levels, optionally glitch-filters them on a prescaled tick,
// captures selected edges into sticky W1C bits and raises a maskable level irq.
// 4-word Avalon-MM slave: registered readdata, zero write wait states.
module cineraria_core_gpio_edgecap #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic             irq
);

    localparam logic [2:0] PRIME_SAT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] samp_q;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] capture_q;
    logic [WIDTH-1:0] capture_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] stable;
    logic [15:0]      div_q;
    logic [15:0]      presc_q;
    logic             rise_en_q;
    logic             fall_en_q;
    logic [2:0]       prime_q;
    logic             edge_en_q;
    logic             tick;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_ctrl;
    logic [31:0]      rd_mux;

    assign wr_en    = chipselect & ~write_n;
    assign wr_mask  = wr_en && (address == 2'd1);
    assign wr_edge  = wr_en && (address == 2'd2);
    assign wr_ctrl  = wr_en && (address == 2'd3);
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A CTRL write reloads the prescaler and suppresses the tick in that cycle.
    assign tick   = (div_q != 16'd0) && (presc_q == 16'd0) && !wr_ctrl;
    assign stable = ~(sync_out ^ samp_q);

    // Prescaler and glitch filter; DIV==0 bypasses the filter entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            samp_q  <= '0;
            filt_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                presc_q <= writedata[23:8];
            end else if (div_q != 16'd0) begin
                presc_q <= (presc_q == 16'd0) ? div_q : presc_q - 16'd1;
            end
            if (div_q == 16'd0) begin
                filt_q <= sync_out;
            end else if (tick) begin
                samp_q <= sync_out;
                filt_q <= (filt_q & ~stable) | (sync_out & stable);
            end
        end
    end

    // Priming: edge_en is registered one cycle past saturation because prev lags
    // filt by one more flop than the synchroniser, so the first filt==1 at reset
    // release would otherwise still look like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_q   <= '0;
            edge_en_q <= 1'b0;
            prev_q    <= '0;
        end else begin
            if (prime_q != PRIME_SAT) begin
                prime_q <= prime_q + 3'd1;
            end
            edge_en_q <= (prime_q == PRIME_SAT);
            prev_q    <= filt_q;
        end
    end

    // Edge detect and sticky capture; a set in the same cycle as a clear wins.
    always_comb begin
        rise      = filt_q & ~prev_q & {WIDTH{rise_en_q & edge_en_q}};
        fall      = ~filt_q & prev_q & {WIDTH{fall_en_q & edge_en_q}};
        clr       = wr_edge ? writedata[WIDTH-1:0] : '0;
        capture_d = (capture_q & ~clr) | rise | fall;
    end

    // Software-visible registers and the registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_q <= '0;
            mask_q    <= '0;
            rise_en_q <= 1'b1;
            fall_en_q <= 1'b0;
            div_q     <= '0;
            irq       <= 1'b0;
        end else begin
            capture_q <= capture_d;
            if (wr_mask) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            if (wr_ctrl) begin
                rise_en_q <= writedata[0];
                fall_en_q <= writedata[1];
                div_q     <= writedata[23:8];
            end
            irq <= |(capture_q & mask_q);
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: rd_mux[WIDTH-1:0] = filt_q;
            2'd1: rd_mux[WIDTH-1:0] = mask_q;
            2'd2: rd_mux[WIDTH-1:0] = capture_q;
            2'd3: begin
                rd_mux[0]    = rise_en_q;
                rd_mux[1]    = fall_en_q;
                rd_mux[23:8] = div_q;
            end
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated every clock regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_cineraria_core_gpio_edgecap.sv
// Scoreboard bench for cineraria_core_gpio_edgecap: drivers push expected
// readdata/irq values tagged with the cycle they are due; a monitor compares them.
module tb_cineraria_core_gpio_edgecap;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] pin_in;
    logic        irq;

    typedef struct {
        int unsigned due;
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    cineraria_core_gpio_edgecap #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pin_in     (pin_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                checks++;
                if (sb_q[i].due != cyc) begin
                    errors++;
                    $display("FAIL %s: stale at cycle %0d, due %0d", sb_q[i].name, cyc,
                             sb_q[i].due);
                end else if (sb_q[i].is_irq) begin
                    if (irq !== sb_q[i].exp[0]) begin
                        errors++;
                        $display("FAIL %s: irq got %b expected %b", sb_q[i].name, irq,
                                 sb_q[i].exp[0]);
                    end
                end else if (readdata !== sb_q[i].exp) begin
                    errors++;
                    $display("FAIL %s: readdata got %h expected %h", sb_q[i].name,
                             readdata, sb_q[i].exp);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_rd(input int unsigned due, input logic [31:0] exp, input string name);
        exp_t e;
        e.due = due; e.is_irq = 1'b0; e.exp = exp; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expect_irq(input int unsigned due, input logic val, input string name);
        exp_t e;
        e.due = due; e.is_irq = 1'b1; e.exp = {31'd0, val}; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        expect_rd(cyc + 1, exp, name);
        step(1);
    endtask

    initial begin
        int unsigned n;
        int unsigned w;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        pin_in     = 32'hFFFF_FFFF;
        step(3);

        // Reset state and priming with all pins high at release.
        expect_rd(cyc, 32'h0, "rst_readdata");
        expect_irq(cyc, 1'b0, "rst_irq");
        step(1);
        reset_n = 1'b1;
        step(10);
        bus_read(2'd2, 32'h0, "t1_edge");
        bus_read(2'd0, 32'hFFFF_FFFF, "t1_data");
        bus_read(2'd3, 32'h1, "t1_ctrl");
        expect_irq(cyc, 1'b0, "t1_irq");

        // Bypass latency of a rising edge on bit 0, then W1C clears irq.
        bus_write(2'd1, 32'h1);
        pin_in = 32'h0;
        step(5);
        bus_read(2'd2, 32'h0, "t2_edge_idle");
        address = 2'd0;
        n = cyc + 1;
        pin_in = 32'h1;
        expect_rd(n + 2, 32'h0, "t2_data_n2");
        expect_rd(n + 3, 32'h1, "t2_data_n3");
        expect_irq(n + 3, 1'b0, "t2_irq_n3");
        expect_irq(n + 4, 1'b1, "t2_irq_n4");
        step(4);
        address = 2'd2;
        expect_rd(n + 4, 32'h1, "t2_edge_n4");
        step(1);
        w = cyc + 1;
        expect_irq(w, 1'b1, "t2_irq_at_w1c");
        expect_irq(w + 1, 1'b0, "t2_irq_after_w1c");
        bus_write(2'd2, 32'h1);
        step(1);
        bus_read(2'd2, 32'h0, "t2_edge_cleared");

        // Falling-only capture on bit 5; writing 0 to EDGE has no effect.
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, 32'h2, "t3_ctrl");
        pin_in = 32'h21;
        step(5);
        pin_in = 32'h01;
        step(5);
        pin_in = 32'h21;
        step(5);
        bus_read(2'd2, 32'h20, "t3_edge");
        expect_irq(cyc, 1'b0, "t3_irq_masked");
        bus_write(2'd2, 32'h0);
        bus_read(2'd2, 32'h20, "t3_edge_w0");
        bus_write(2'd2, 32'h20);

        // Glitch filter with DIV=4: short glitch rejected, long pulse passes.
        bus_write(2'd3, 32'h0000_0401);
        bus_read(2'd3, 32'h0000_0401, "t4_ctrl");
        step(10);
        pin_in = 32'h29;
        step(3);
        pin_in = 32'h21;
        step(15);
        bus_read(2'd0, 32'h21, "t4_glitch_data");
        bus_read(2'd2, 32'h0, "t4_glitch_edge");
        pin_in = 32'h29;
        step(18);
        bus_read(2'd0, 32'h29, "t4_pulse_data");
        bus_read(2'd2, 32'h8, "t4_pulse_edge");
        pin_in = 32'h21;
        step(15);
        bus_write(2'd2, 32'h8);
        bus_write(2'd3, 32'h1);
        step(3);

        // Edge on bit 2 lands on the same edge as a W1C of bit 2: set wins.
        pin_in = 32'h25;
        step(3);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, 32'h4, "t5_set_wins");
        expect_irq(cyc, 1'b0, "t5_irq_masked");
        bus_write(2'd2, 32'h4);

        // Asynchronous reset mid-capture with irq asserted.
        bus_write(2'd3, 32'h3);
        pin_in = 32'h24;
        step(5);
        pin_in = 32'h26;
        step(5);
        bus_write(2'd2, 32'h4);
        step(3);
        bus_write(2'd1, 32'hF);
        bus_read(2'd2, 32'h3, "t6_edge_pre");
        expect_irq(cyc, 1'b1, "t6_irq_pre");
        step(1);
        reset_n = 1'b0;
        expect_rd(cyc, 32'h0, "t6_readdata_async");
        expect_irq(cyc, 1'b0, "t6_irq_async");
        step(2);
        reset_n = 1'b1;
        step(1);
        bus_read(2'd1, 32'h0, "t6_mask");
        bus_read(2'd2, 32'h0, "t6_edge");
        bus_read(2'd3, 32'h1, "t6_ctrl");
        step(8);
        bus_read(2'd2, 32'h0, "t6_edge_primed");
        bus_read(2'd0, 32'h26, "t6_data");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors += sb_q.size();
            $display("FAIL scoreboard: %0d expectations never checked", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
